// File: rtl/debounce_bank.sv
// debounce_bank: per-channel input synchronizer and debouncer.
// Each raw input is synchronized, then must hold a new level for CNT_MAX
// enabled cycles before it is accepted onto a_stable. Accepted changes
// also produce one-cycle rise/fall pulses. All outputs are registered.
module debounce_bank #(
    parameter int width       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_MAX     = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [width-1:0] a_raw,
    output logic [width-1:0] a_stable,
    output logic [width-1:0] rise,
    output logic [width-1:0] fall,
    output logic             busy
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    // sync_q[0] takes the raw sample; the last stage is the clean level
    logic [SYNC_STAGES-1:0][width-1:0] sync_q;
    logic [width-1:0]                  s;

    logic [width-1:0][CW-1:0] cnt_q, cnt_d;
    logic [width-1:0]         stable_q, stable_d;
    logic [width-1:0]         rise_q, rise_d;
    logic [width-1:0]         fall_q, fall_d;
    logic                     busy_q, busy_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain: shift the raw vector one stage per clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], a_raw};
    end

    // Per-channel debounce decision; a match at any time abandons the count
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        busy_d   = 1'b0;
        for (int i = 0; i < width; i++) begin
            if (s[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (en) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s[i];
                    cnt_d[i]    = '0;
                    rise_d[i]   = s[i];
                    fall_d[i]   = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            // busy tracks the counters as they will be after this edge
            busy_d = busy_d | (cnt_d[i] != '0);
        end
    end

    // Debounce state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    assign a_stable = stable_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with width=8, SYNC_STAGES=2, CNT_MAX=4.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [7:0] a_raw = 8'h00;
    logic [7:0] a_stable, rise, fall;
    logic       busy;
    logic       y;

    int tests = 0;
    int fails = 0;

    debounce_bank #(.width(8), .SYNC_STAGES(2), .CNT_MAX(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .a_raw    (a_raw),
        .a_stable (a_stable),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
    );

    // Downstream andN stand-in
    assign y = &a_stable;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("in_reset", {a_stable, rise, fall, 7'd0, busy}, 32'h0);
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        // 1: quiet after reset release
        a_raw = 8'h00; en = 1'b1;
        do_reset();
        for (int k = 0; k < 20; k++)
            chk("idle", {a_stable, rise, fall, 7'd0, busy}, 32'h0);
        for (int k = 0; k < 20; k++) tick(1);

        // 2: single channel rise, latency SYNC_STAGES+CNT_MAX-1 = 5 edges after sampling
        do_reset();
        a_raw = 8'h01;
        tick(2); chk("ch0_busy_n1", {31'd0, busy}, 32'd0);
        tick(1); chk("ch0_busy_n2", {31'd0, busy}, 32'd1);
        tick(2); chk("ch0_pre",     {a_stable, rise, 7'd0, busy}, {8'h00, 8'h00, 8'h01});
        tick(1); chk("ch0_accept",  {a_stable, rise, 7'd0, busy}, {8'h01, 8'h01, 8'h00});
        tick(1); chk("ch0_post",    {a_stable, rise, fall},      {8'h00, 8'h01, 8'h00, 8'h00});

        // 3: 3-cycle glitch on channel 3 is rejected
        do_reset();
        a_raw = 8'h08;
        tick(3);
        a_raw = 8'h00;
        for (int k = 0; k < 10; k++) begin
            chk("glitch", {a_stable, rise, fall}, 32'h0);
            tick(1);
        end
        chk("glitch_busy", {31'd0, busy}, 32'd0);

        // 4: en high one cycle in three; accept on the 4th enabled edge (j=12)
        do_reset();
        a_raw = 8'h20;
        for (int j = 1; j <= 14; j++) begin
            en = (j % 3 == 0);
            tick(1);
            chk($sformatf("engate_j%0d", j), {16'd0, a_stable, rise},
                {16'd0, (j >= 12) ? 8'h20 : 8'h00, (j == 12) ? 8'h20 : 8'h00});
        end
        en = 1'b1;

        // 5: simultaneous acceptance across channels
        do_reset();
        a_raw = 8'hFF;
        tick(5); chk("all_pre",  {rise, 7'd0, y}, {8'h00, 8'h00});
        tick(1); chk("all_rise", {a_stable, rise, 7'd0, y}, {8'hFF, 8'hFF, 8'h01});
        tick(1); chk("all_rise_end", {16'd0, rise, fall}, 32'h0);
        a_raw = 8'h0F;
        tick(5); chk("hi_pre",   {fall, 7'd0, y}, {8'h00, 8'h01});
        tick(1); chk("hi_fall",  {a_stable, rise, fall, 7'd0, y}, {8'h0F, 8'h00, 8'hF0, 8'h00});
        tick(1); chk("hi_fall_end", {16'd0, rise, fall}, 32'h0);

        // 6: async reset mid-count, then full latency again
        do_reset();
        a_raw = 8'h02;
        tick(7); chk("ch1_held", {24'd0, a_stable}, 32'h02);
        a_raw = 8'h03;
        tick(4); chk("mid_count", {a_stable, 7'd0, busy}, {8'h02, 8'h01});
        #2 reset = 1'b1;
        #1 chk("async_rst", {a_stable, rise, fall, 7'd0, busy}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(5); chk("rel_pre",    {16'd0, a_stable, rise}, 32'h0);
        tick(1); chk("rel_accept", {16'd0, a_stable, rise}, {16'd0, 8'h03, 8'h03});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
